// File: rtl/update_seq_ctrl.sv
// Remote-update sequencer: clear switch code, write bitstream, CRC check,
// write switch code and optional hot reset, with per-step timeout and error code.
module update_seq_ctrl #(
    parameter logic [1:0]  USER_BITSTREAM_CNT = 2'd1,
    parameter logic [31:0] TIMEOUT_CYCLES     = 32'd50_000_000,
    parameter logic        AUTO_HOTRESET      = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       upd_start,
    input  logic       upd_abort,
    input  logic [1:0] upd_bs_num,
    output logic       clear_sw_en,
    output logic       flash_wr_en,
    output logic [1:0] bitstream_wr_num,
    output logic       crc_check_en,
    output logic       write_sw_code_en,
    output logic       hotreset_en,
    input  logic       clear_sw_done,
    input  logic       clear_bs_done,
    input  logic       bitstream_wr_done,
    input  logic [1:0] bs_crc32_ok,
    input  logic       open_sw_code_done,
    input  logic       ipal_busy,
    output logic       upd_busy,
    output logic       upd_done,
    output logic       upd_err,
    output logic [3:0] upd_err_code,
    output logic [2:0] upd_step
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR_SW = 3'd1,
        S_WR_BS  = 3'd2,
        S_CRC    = 3'd3,
        S_WR_SW  = 3'd4,
        S_HOTRST = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t      r_state;
    logic        r_first;
    logic [31:0] r_cnt;
    logic        r_bs_cleared;
    logic [1:0]  r_bs_num;
    logic [3:0]  r_err_code;
    logic        r_busy;

    state_t      w_next;
    logic        w_err_load;
    logic [3:0]  w_err_val;
    logic        w_cnt_restart;
    logic        w_hotreset;
    logic        w_step_state;
    logic        w_timeout;
    logic        w_legal_num;
    logic        w_accept;

    assign w_step_state = (r_state == S_CLR_SW) || (r_state == S_WR_BS) ||
                          (r_state == S_CRC)    || (r_state == S_WR_SW) ||
                          (r_state == S_HOTRST);
    assign w_timeout    = (r_cnt == (TIMEOUT_CYCLES - 32'd1));
    assign w_legal_num  = (upd_bs_num != 2'd0) && (upd_bs_num <= USER_BITSTREAM_CNT);
    assign w_accept     = (r_state == S_IDLE) && (w_next == S_CLR_SW);

    always_comb begin
        w_next        = r_state;
        w_err_load    = 1'b0;
        w_err_val     = 4'h0;
        w_cnt_restart = 1'b0;
        w_hotreset    = 1'b0;
        // Abort pre-empts any done pulse seen in the same cycle.
        if (w_step_state && upd_abort) begin
            w_next     = S_ERR;
            w_err_load = 1'b1;
            w_err_val  = 4'hF;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (upd_start && !upd_abort) begin
                        if (w_legal_num) begin
                            w_next = S_CLR_SW;
                        end else begin
                            w_next     = S_ERR;
                            w_err_load = 1'b1;
                            w_err_val  = 4'h1;
                        end
                    end
                end
                S_CLR_SW: begin
                    if (clear_sw_done) begin
                        w_next = S_WR_BS;
                    end else if (w_timeout) begin
                        w_next     = S_ERR;
                        w_err_load = 1'b1;
                        w_err_val  = 4'h2;
                    end
                end
                S_WR_BS: begin
                    // Write-done only counts once the erase has been reported.
                    if (r_bs_cleared && bitstream_wr_done) begin
                        w_next = S_CRC;
                    end else if (!r_bs_cleared && clear_bs_done) begin
                        w_cnt_restart = 1'b1;
                    end else if (w_timeout) begin
                        w_next     = S_ERR;
                        w_err_load = 1'b1;
                        w_err_val  = 4'h3;
                    end
                end
                S_CRC: begin
                    if (bs_crc32_ok[1]) begin
                        if (bs_crc32_ok[0]) begin
                            w_next     = S_ERR;
                            w_err_load = 1'b1;
                            w_err_val  = 4'h4;
                        end else begin
                            w_next = S_WR_SW;
                        end
                    end else if (w_timeout) begin
                        w_next     = S_ERR;
                        w_err_load = 1'b1;
                        w_err_val  = 4'h5;
                    end
                end
                S_WR_SW: begin
                    if (open_sw_code_done) begin
                        w_next = AUTO_HOTRESET ? S_HOTRST : S_DONE;
                    end else if (w_timeout) begin
                        w_next     = S_ERR;
                        w_err_load = 1'b1;
                        w_err_val  = 4'h6;
                    end
                end
                S_HOTRST: begin
                    if (!ipal_busy) begin
                        w_hotreset = 1'b1;
                        w_next     = S_DONE;
                    end else if (w_timeout) begin
                        w_next     = S_ERR;
                        w_err_load = 1'b1;
                        w_err_val  = 4'h7;
                    end
                end
                S_DONE:  w_next = S_IDLE;
                S_ERR:   w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_first      <= 1'b0;
            r_cnt        <= 32'd0;
            r_bs_cleared <= 1'b0;
            r_bs_num     <= 2'd0;
            r_err_code   <= 4'h0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= (w_next != r_state);
            if ((w_next != r_state) || w_cnt_restart || !w_step_state) begin
                r_cnt <= 32'd0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_next != r_state) begin
                r_bs_cleared <= 1'b0;
            end else if (w_cnt_restart) begin
                r_bs_cleared <= 1'b1;
            end
            if (w_accept) begin
                r_bs_num   <= upd_bs_num;
                r_err_code <= 4'h0;
            end else if (w_err_load) begin
                r_err_code <= w_err_val;
            end
            // An illegal-slot start is never accepted, so it does not raise busy.
            if (w_next == S_IDLE) begin
                r_busy <= 1'b0;
            end else if (w_accept) begin
                r_busy <= 1'b1;
            end
        end
    end

    assign clear_sw_en      = (r_state == S_CLR_SW) && r_first;
    assign flash_wr_en      = (r_state == S_WR_BS);
    assign crc_check_en     = (r_state == S_CRC) && r_first;
    assign write_sw_code_en = (r_state == S_WR_SW) && r_first;
    assign hotreset_en      = w_hotreset;
    assign bitstream_wr_num = r_bs_num;
    assign upd_busy         = r_busy;
    assign upd_done         = (r_state == S_DONE);
    assign upd_err          = (r_state == S_ERR);
    assign upd_err_code     = r_err_code;
    assign upd_step         = r_state;

endmodule

// File: tb/tb_update_seq_ctrl.sv
// Directed bench for update_seq_ctrl: stub flash/IPAL handshakes, scoreboard of
// sequence outcomes (done or error code), pulse counters on every enable.
module tb_update_seq_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       upd_start;
    logic       upd_abort;
    logic [1:0] upd_bs_num;
    logic       clear_sw_en;
    logic       flash_wr_en;
    logic [1:0] bitstream_wr_num;
    logic       crc_check_en;
    logic       write_sw_code_en;
    logic       hotreset_en;
    logic       clear_sw_done;
    logic       clear_bs_done;
    logic       bitstream_wr_done;
    logic [1:0] bs_crc32_ok;
    logic       open_sw_code_done;
    logic       ipal_busy;
    logic       upd_busy;
    logic       upd_done;
    logic       upd_err;
    logic [3:0] upd_err_code;
    logic [2:0] upd_step;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_clr, cnt_crc, cnt_wsw, cnt_hot, cnt_done, flash_cyc;

    // Expected outcome: {err, done, code}
    logic [5:0] exp_q[$];

    update_seq_ctrl #(
        .USER_BITSTREAM_CNT (2'd1),
        .TIMEOUT_CYCLES     (32'd100),
        .AUTO_HOTRESET      (1'b1)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .upd_start         (upd_start),
        .upd_abort         (upd_abort),
        .upd_bs_num        (upd_bs_num),
        .clear_sw_en       (clear_sw_en),
        .flash_wr_en       (flash_wr_en),
        .bitstream_wr_num  (bitstream_wr_num),
        .crc_check_en      (crc_check_en),
        .write_sw_code_en  (write_sw_code_en),
        .hotreset_en       (hotreset_en),
        .clear_sw_done     (clear_sw_done),
        .clear_bs_done     (clear_bs_done),
        .bitstream_wr_done (bitstream_wr_done),
        .bs_crc32_ok       (bs_crc32_ok),
        .open_sw_code_done (open_sw_code_done),
        .ipal_busy         (ipal_busy),
        .upd_busy          (upd_busy),
        .upd_done          (upd_done),
        .upd_err           (upd_err),
        .upd_err_code      (upd_err_code),
        .upd_step          (upd_step)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] mk(input logic is_err, input logic [3:0] code);
        return {is_err, ~is_err, code};
    endfunction

    // Scoreboard and pulse counters, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            cnt_clr   = cnt_clr + int'(clear_sw_en);
            cnt_crc   = cnt_crc + int'(crc_check_en);
            cnt_wsw   = cnt_wsw + int'(write_sw_code_en);
            cnt_hot   = cnt_hot + int'(hotreset_en);
            cnt_done  = cnt_done + int'(upd_done);
            flash_cyc = flash_cyc + int'(flash_wr_en);
            if (upd_done || upd_err) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL sb_unexpected: observed done=%0b err=%0b code=%0h expected no result",
                           upd_done, upd_err, upd_err_code);
                end else begin
                    logic [5:0] e;
                    e = exp_q.pop_front();
                    check("sb_result", {26'd0, upd_err, upd_done, upd_err_code}, {26'd0, e});
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        cnt_clr = 0; cnt_crc = 0; cnt_wsw = 0; cnt_hot = 0; cnt_done = 0; flash_cyc = 0;
    endtask

    task automatic do_start(input logic [1:0] num);
        upd_start  = 1'b1;
        upd_bs_num = num;
        tick();
        upd_start  = 1'b0;
    endtask

    // 0 clear_sw_done, 1 clear_bs_done, 2 bitstream_wr_done, 3 crc ok, 4 crc bad, 5 sw code done
    task automatic pulse(input int which);
        case (which)
            0: clear_sw_done     = 1'b1;
            1: clear_bs_done     = 1'b1;
            2: bitstream_wr_done = 1'b1;
            3: bs_crc32_ok       = 2'b10;
            4: bs_crc32_ok       = 2'b11;
            default: open_sw_code_done = 1'b1;
        endcase
        tick();
        clear_sw_done = 1'b0; clear_bs_done = 1'b0; bitstream_wr_done = 1'b0;
        bs_crc32_ok = 2'b00; open_sw_code_done = 1'b0;
    endtask

    task automatic wait_step(input logic [2:0] st, input int maxc, input string tag);
        int n;
        n = 0;
        while (upd_step !== st && n < maxc) begin
            tick();
            n++;
        end
        check(tag, {29'd0, upd_step}, {29'd0, st});
    endtask

    task automatic to_wr_bs();
        do_start(2'd1);
        gap(10);
        pulse(0);
    endtask

    task automatic to_crc();
        to_wr_bs();
        gap(10);
        pulse(1);
        gap(10);
        pulse(2);
    endtask

    task automatic finish_ok();
        gap(10);
        pulse(3);
        gap(10);
        pulse(5);
        wait_step(3'd0, 10, "finish_idle");
    endtask

    function automatic logic [31:0] all_outs();
        return {13'd0, clear_sw_en, flash_wr_en, bitstream_wr_num, crc_check_en,
                write_sw_code_en, hotreset_en, upd_busy, upd_done, upd_err,
                upd_err_code, upd_step};
    endfunction

    initial begin
        #200_000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sys_rst = 1'b1; upd_start = 1'b0; upd_abort = 1'b0; upd_bs_num = 2'd0;
        clear_sw_done = 1'b0; clear_bs_done = 1'b0; bitstream_wr_done = 1'b0;
        bs_crc32_ok = 2'b00; open_sw_code_done = 1'b0; ipal_busy = 1'b0;
        clear_counts();
        gap(3);
        check("reset_outputs", all_outs(), 32'd0);
        sys_rst = 1'b0;
        tick();

        // Happy path
        clear_counts();
        exp_q.push_back(mk(1'b0, 4'h0));
        do_start(2'd1);
        check("happy_clr_step", {29'd0, upd_step}, 32'd1);
        check("happy_busy", {31'd0, upd_busy}, 32'd1);
        gap(10); pulse(0);
        check("happy_wrbs_flash", {31'd0, flash_wr_en}, 32'd1);
        gap(10); pulse(1);
        gap(10); pulse(2);
        check("happy_crc_step", {29'd0, upd_step}, 32'd3);
        check("happy_flash_low", {31'd0, flash_wr_en}, 32'd0);
        check("happy_slot", {30'd0, bitstream_wr_num}, 32'd1);
        finish_ok();
        check("happy_clr_cnt", cnt_clr, 1);
        check("happy_crc_cnt", cnt_crc, 1);
        check("happy_wsw_cnt", cnt_wsw, 1);
        check("happy_hot_cnt", cnt_hot, 1);
        check("happy_done_cnt", cnt_done, 1);
        check("happy_flash_cyc", flash_cyc, 22);
        check("happy_code", {28'd0, upd_err_code}, 32'd0);
        check("happy_idle_busy", {31'd0, upd_busy}, 32'd0);

        // CRC failure
        clear_counts();
        exp_q.push_back(mk(1'b1, 4'h4));
        to_crc();
        gap(10); pulse(4);
        check("crcfail_err_step", {29'd0, upd_step}, 32'd7);
        tick();
        check("crcfail_idle", {29'd0, upd_step}, 32'd0);
        check("crcfail_code", {28'd0, upd_err_code}, 32'h4);
        check("crcfail_no_wsw", cnt_wsw, 0);

        // Timeout in WR_BS: exactly 100 cycles
        exp_q.push_back(mk(1'b1, 4'h3));
        to_wr_bs();
        gap(99);
        check("tmo_last_cycle", {29'd0, upd_step}, 32'd2);
        tick();
        check("tmo_err_step", {29'd0, upd_step}, 32'd7);
        check("tmo_code", {28'd0, upd_err_code}, 32'h3);
        tick();

        // Dones on the last allowed cycle win over the timeout
        exp_q.push_back(mk(1'b0, 4'h0));
        to_wr_bs();
        gap(99); pulse(1);
        check("tmo99_erase", {29'd0, upd_step}, 32'd2);
        gap(99); pulse(2);
        check("tmo99_crc", {29'd0, upd_step}, 32'd3);
        check("tmo99_code_clr", {28'd0, upd_err_code}, 32'h0);
        finish_ok();

        // Illegal slots
        clear_counts();
        exp_q.push_back(mk(1'b1, 4'h1));
        do_start(2'd2);
        check("ill2_step", {29'd0, upd_step}, 32'd7);
        tick();
        exp_q.push_back(mk(1'b1, 4'h1));
        do_start(2'd0);
        check("ill0_code", {28'd0, upd_err_code}, 32'h1);
        tick();
        check("ill_no_enables", cnt_clr + cnt_crc + cnt_wsw + cnt_hot + flash_cyc, 0);

        // Start while busy, then abort 5 cycles into WR_BS
        clear_counts();
        exp_q.push_back(mk(1'b1, 4'hF));
        to_wr_bs();
        gap(2);
        do_start(2'd1);
        check("busy_start_step", {29'd0, upd_step}, 32'd2);
        check("busy_start_clr", cnt_clr, 1);
        gap(2);
        upd_abort = 1'b1;
        check("abort_flash_pre", {31'd0, flash_wr_en}, 32'd1);
        tick();
        upd_abort = 1'b0;
        check("abort_flash_low", {31'd0, flash_wr_en}, 32'd0);
        check("abort_code", {28'd0, upd_err_code}, 32'hF);
        wait_step(3'd0, 5, "abort_idle");

        // Abort and start together in IDLE: nothing happens
        upd_abort = 1'b1; upd_start = 1'b1; upd_bs_num = 2'd1;
        tick();
        upd_abort = 1'b0; upd_start = 1'b0;
        check("abort_start_idle", {29'd0, upd_step}, 32'd0);
        check("abort_start_busy", {31'd0, upd_busy}, 32'd0);

        // ipal_busy stuck in HOTRST
        clear_counts();
        exp_q.push_back(mk(1'b1, 4'h7));
        to_crc();
        gap(10); pulse(3);
        ipal_busy = 1'b1;
        gap(10); pulse(5);
        gap(99);
        check("hot_wait_step", {29'd0, upd_step}, 32'd5);
        tick();
        check("hot_err_step", {29'd0, upd_step}, 32'd7);
        check("hot_code", {28'd0, upd_err_code}, 32'h7);
        check("hot_no_pulse", cnt_hot, 0);
        ipal_busy = 1'b0;
        wait_step(3'd0, 5, "hot_idle");

        // Reset mid-CRC, then a clean run
        to_crc();
        gap(3);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("midrst_outputs", all_outs(), 32'd0);
        clear_counts();
        exp_q.push_back(mk(1'b0, 4'h0));
        to_crc();
        finish_ok();
        check("midrst_done_cnt", cnt_done, 1);
        check("midrst_hot_cnt", cnt_hot, 1);

        gap(5);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/update_seq_ctrl.md
Name: update_seq_ctrl

Overview:
- Hardware sequencer for one complete remote-update transaction on the flash/IPAL resources.
- Runs clear switch code, write bitstream, readback CRC check, write switch code, then an optional hot reset, from a single start pulse.
- Sits between the command decoder and the SPI flash/IPAL engines, and drives their existing enable/done handshakes.
- Adds per-step timeout supervision and a latched error code, so software issues one command instead of five.

Parameters:
- USER_BITSTREAM_CNT, 2'd1: number of user bitstream slots; legal target numbers are 1..USER_BITSTREAM_CNT.
- TIMEOUT_CYCLES, 32'd50_000_000: maximum sys_clk cycles allowed per step before a timeout error.
- AUTO_HOTRESET, 1'b1: 1 = issue hotreset_en after a successful sequence; 0 = finish in DONE without reset.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- upd_start  in  1  one-cycle request to begin a sequence.
- upd_abort  in  1  one-cycle request to stop the running sequence.
- upd_bs_num  in  2  target bitstream slot; sampled on the upd_start cycle.
- clear_sw_en  out  1  one-cycle pulse: erase switch code.
- flash_wr_en  out  1  level: bitstream erase+write active.
- bitstream_wr_num  out  2  slot number, held for the whole sequence.
- crc_check_en  out  1  one-cycle pulse: start readback CRC.
- write_sw_code_en  out  1  one-cycle pulse: write switch code.
- hotreset_en  out  1  one-cycle pulse: IPAL hot reset.
- clear_sw_done  in  1  pulse from flash engine.
- clear_bs_done  in  1  pulse: bitstream region erased.
- bitstream_wr_done  in  1  pulse: bitstream written.
- bs_crc32_ok  in  2  [1] valid pulse, [0] 0 = OK, 1 = error.
- open_sw_code_done  in  1  pulse: switch code written.
- ipal_busy  in  1  IPAL engine busy.
- upd_busy  out  1  high from the cycle after an accepted start until the cycle before returning to IDLE.
- upd_done  out  1  one-cycle success pulse.
- upd_err  out  1  one-cycle failure pulse.
- upd_err_code  out  4  latched error cause.
- upd_step  out  3  current state encoding, for debug.

Behaviour:
- Reset: all outputs are 0, state is IDLE, timeout counter is 0, bitstream_wr_num is 0.
- States and encoding: IDLE=0, CLR_SW=1, WR_BS=2, CRC=3, WR_SW=4, HOTRST=5, DONE=6, ERR=7. upd_step is the registered state.
- IDLE:
  - upd_start with upd_bs_num in 1..USER_BITSTREAM_CNT → CLR_SW. On the same edge, latch bitstream_wr_num and clear upd_err_code to 0.
  - upd_start with an illegal number → ERR with code 4'h1.
  - upd_start while not in IDLE is ignored.
- Every step state: the enable pulse is asserted in the first cycle after entry only. The timeout counter clears on every state entry and increments every cycle in that state.
- CLR_SW: pulses clear_sw_en; waits for clear_sw_done, then → WR_BS. Timeout → ERR, code 4'h2.
- WR_BS:
  - flash_wr_en is held high for the whole state.
  - Needs clear_bs_done, then bitstream_wr_done. bitstream_wr_done before clear_bs_done is ignored.
  - The timeout counter also restarts on clear_bs_done.
  - bitstream_wr_done → CRC, with flash_wr_en low from that edge.
  - Timeout → ERR, code 4'h3.
- CRC: pulses crc_check_en; waits for bs_crc32_ok[1].
  - bs_crc32_ok[0]=0 → WR_SW.
  - bs_crc32_ok[0]=1 → ERR, code 4'h4.
  - Timeout → ERR, code 4'h5.
- WR_SW: pulses write_sw_code_en; waits for open_sw_code_done.
  - Done with AUTO_HOTRESET=1 → HOTRST; done with AUTO_HOTRESET=0 → DONE.
  - Timeout → ERR, code 4'h6.
- HOTRST: waits for ipal_busy=0, then pulses hotreset_en for 1 cycle → DONE. ipal_busy high for the full timeout → ERR, code 4'h7.
- DONE: upd_done=1 for one cycle → IDLE.
- ERR: upd_err=1 for one cycle, upd_err_code latched → IDLE. The code holds until the next accepted start.
- Timeout condition: counter == TIMEOUT_CYCLES-1 with no qualifying done in that cycle. A done and a timeout in the same cycle resolve as done.
- upd_abort in any step state (1..5) → ERR, code 4'hF:
  - all enables go low on that edge, including flash_wr_en;
  - done pulses arriving in that cycle are ignored.
- upd_abort in IDLE, DONE or ERR is ignored. upd_abort and upd_start together in IDLE: abort wins and the start is dropped.
- Done pulses arriving in states that do not wait for them are ignored.
- sys_rst asserted mid-sequence returns to reset values on the next edge. No error pulse is produced.
- Width rule: the timeout counter is 32 bits, with no wrap before TIMEOUT_CYCLES-1.

Test Plan:
- Happy path: TIMEOUT_CYCLES=100, AUTO_HOTRESET=1, start with num=1; stub each done 10 cycles after its enable; crc ok=2'b10 → exactly 1 pulse each of clear_sw_en, crc_check_en, write_sw_code_en and hotreset_en; flash_wr_en high from entering WR_BS until bitstream_wr_done; upd_done=1 once; upd_err_code=0.
- CRC fail: same stimulus but bs_crc32_ok=2'b11 → no write_sw_code_en; upd_err pulse; upd_err_code=4'h4; upd_step returns to 0.
- Timeout: withhold clear_bs_done in WR_BS → ERR after exactly 100 cycles; code 4'h3. Second case: give done on cycle 99 → proceeds to CRC with no error.
- Illegal slot: USER_BITSTREAM_CNT=1, start with num=2 and with num=0 → immediate upd_err; code 4'h1; no enables ever asserted.
- Abort and busy: abort 5 cycles into WR_BS → flash_wr_en low on the next edge; code 4'hF. A second upd_start while busy produces no change. ipal_busy held high in HOTRST → code 4'h7.
- Reset mid-CRC: assert sys_rst for 1 cycle → all outputs 0; no upd_err; a new start then runs cleanly.
